cic_decimator: RTL and testbench

//  Parametrised N-stage CIC decimator for a single audio channel. Integrates
//  at the input sample rate (clkEnA) and combs at the output rate (clkEnB).
//  The comb result is scaled by a fixed right shift, rounded and saturated.

---
 rtl/cic_decimator.sv | 108 ++++++++++
 tb/tb_cic_decimator.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cic_decimator.sv
// N-stage CIC decimator: integrators at the input strobe rate, combs at the
// decimation strobe rate, then a rounded and saturated arithmetic right shift.
module cic_decimator #(
  parameter int ORDER = 3,
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int ACC_W = 37,
  parameter int SHIFT = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkEnA,
  input  logic             clkEnB,
  input  logic             iClr,
  input  logic [IN_W-1:0]  iIn,
  output logic [OUT_W-1:0] oOut,
  output logic             oValid,
  output logic             oSat
);

  localparam int RP = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND  = (SHIFT > 0) ? ((ACC_W+1)'(1) << RP) : '0;
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [ACC_W-1:0] integ [ORDER];
  logic [ACC_W-1:0] comb  [ORDER];
  logic [ACC_W-1:0] dly   [ORDER];
  logic             pend;
  logic [ACC_W-1:0] in_ext;
  logic signed [ACC_W:0] rsum;
  logic signed [ACC_W:0] rsh;

  assign in_ext = {{(ACC_W-IN_W){iIn[IN_W-1]}}, iIn};

  // Integrator cascade, pipelined on old register values, wrapping modulo 2^ACC_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < ORDER; k++) integ[k] <= '0;
    end else if (iClr) begin
      for (int unsigned k = 0; k < ORDER; k++) integ[k] <= '0;
    end else if (clkEnA) begin
      integ[0] <= integ[0] + in_ext;
      for (int unsigned k = 1; k < ORDER; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  // Comb cascade at the decimated rate; samples the pre-edge last integrator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < ORDER; k++) begin
        comb[k] <= '0;
        dly[k]  <= '0;
      end
      pend <= 1'b0;
    end else if (iClr) begin
      for (int unsigned k = 0; k < ORDER; k++) begin
        comb[k] <= '0;
        dly[k]  <= '0;
      end
      pend <= 1'b0;
    end else begin
      pend <= clkEnB;
      if (clkEnB) begin
        comb[0] <= integ[ORDER-1] - dly[0];
        dly[0]  <= integ[ORDER-1];
        for (int unsigned k = 1; k < ORDER; k++) begin
          comb[k] <= comb[k-1] - dly[k];
          dly[k]  <= comb[k-1];
        end
      end
    end
  end

  // Round half toward +inf, one guard bit above ACC_W so the bias cannot wrap
  always_comb begin
    rsum = $signed({comb[ORDER-1][ACC_W-1], comb[ORDER-1]}) + RND;
    rsh  = rsum >>> SHIFT;
  end

  // Registered, saturated output one clock after the comb update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oOut   <= '0;
      oValid <= 1'b0;
      oSat   <= 1'b0;
    end else if (iClr) begin
      oOut   <= '0;
      oValid <= 1'b0;
      oSat   <= 1'b0;
    end else begin
      oValid <= pend;
      if (pend) begin
        if (rsh > MAXV) begin
          oOut <= MAXV[OUT_W-1:0];
          oSat <= 1'b1;
        end else if (rsh < MINV) begin
          oOut <= MINV[OUT_W-1:0];
          oSat <= 1'b1;
        end else begin
          oOut <= rsh[OUT_W-1:0];
          oSat <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench: four decimator instances with different parameters share
// one stimulus stream; each step checks the instance the step is aimed at.
module tb_cic_decimator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clkEnA = 1'b0;
  logic        clkEnB = 1'b0;
  logic        iClr = 1'b0;
  logic [15:0] iIn = '0;

  logic signed [15:0] o3, o1, oS, oW;
  logic v3, v1, vS, vW;
  logic s3, s1, sS, sW;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cic_decimator u3 (
    .clk(clk), .rst(rst), .clkEnA(clkEnA), .clkEnB(clkEnB), .iClr(iClr),
    .iIn(iIn), .oOut(o3), .oValid(v3), .oSat(s3));

  cic_decimator #(.ORDER(1), .SHIFT(3)) u1 (
    .clk(clk), .rst(rst), .clkEnA(clkEnA), .clkEnB(clkEnB), .iClr(iClr),
    .iIn(iIn), .oOut(o1), .oValid(v1), .oSat(s1));

  cic_decimator #(.ORDER(3), .SHIFT(4)) uS (
    .clk(clk), .rst(rst), .clkEnA(clkEnA), .clkEnB(clkEnB), .iClr(iClr),
    .iIn(iIn), .oOut(oS), .oValid(vS), .oSat(sS));

  cic_decimator #(.ORDER(3), .ACC_W(22), .SHIFT(6)) uW (
    .clk(clk), .rst(rst), .clkEnA(clkEnA), .clkEnB(clkEnB), .iClr(iClr),
    .iIn(iIn), .oOut(oW), .oValid(vW), .oSat(sW));

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // na input strobes, one decimation strobe, then sample just after the valid edge
  task automatic period(input logic [15:0] x, input int unsigned na);
    for (int unsigned i = 0; i < na; i++) begin
      @(negedge clk); clkEnA = 1'b1; iIn = x;
    end
    @(negedge clk); clkEnA = 1'b0; clkEnB = 1'b1;
    @(negedge clk); clkEnB = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic clr();
    @(negedge clk); iClr = 1'b1;
    @(negedge clk); iClr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #12;
    chk("rst o3", int'(o3), 0);
    chk("rst v3", int'(v3), 0);
    chk("rst s3", int'(s3), 0);
    @(negedge clk); rst = 1'b0;

    // ORDER=3 pipelined fill: comb output is 0,0,4x,44x,64x,64x...
    for (int k = 1; k <= 5; k++) begin
      period(16'd1234, 4);
      chk("run v3", int'(v3), 1);
      if (k == 3) chk("run B3 o3", int'(o3), 77);
      if (k == 4) chk("run B4 o3", int'(o3), 848);
      if (k == 5) chk("run B5 o3", int'(o3), 1234);
      if (k == 5) chk("run B5 o1", int'(o1), 617);
    end

    // asynchronous reset mid-stream
    @(negedge clk); clkEnA = 1'b1; iIn = 16'd1234;
    #2 rst = 1'b1;
    #1;
    chk("T1 o3", int'(o3), 0);
    chk("T1 v3", int'(v3), 0);
    chk("T1 s3", int'(s3), 0);
    chk("T1 o1", int'(o1), 0);
    @(negedge clk); rst = 1'b0; clkEnA = 1'b0;

    // DC gain, positive
    for (int k = 1; k <= 6; k++) begin
      period(16'd1000, 4);
      chk("T2 v3", int'(v3), 1);
      if (k <= 2) chk("T2 fill o3", int'(o3), 0);
      if (k == 3) chk("T2 B3 o3", int'(o3), 63);
      if (k == 4) chk("T2 B4 o3", int'(o3), 688);
      if (k >= 5) chk("T2 dc o3", int'(o3), 1000);
    end
    @(posedge clk); #1;
    chk("T2 pulse v3", int'(v3), 0);
    chk("T2 hold o3", int'(o3), 1000);

    // DC gain, negative
    clr();
    chk("T2 clr o3", int'(o3), 0);
    for (int k = 1; k <= 6; k++) begin
      period(-16'sd1000, 4);
      if (k == 4) chk("T2 B4 neg o3", int'(o3), -687);
      if (k >= 5) chk("T2 dc neg o3", int'(o3), -1000);
    end

    // rounding half toward +inf
    clr();
    period(16'd1, 4);
    chk("T3 +0.5 o1", int'(o1), 1);
    chk("T3 +0.5 s1", int'(s1), 0);
    clr();
    period(16'hFFFF, 4);
    chk("T3 -0.5 o1", int'(o1), 0);
    chk("T3 -0.5 s1", int'(s1), 0);

    // saturation
    clr();
    for (int k = 1; k <= 6; k++) begin
      period(16'd32767, 4);
      if (k == 3) chk("T4 B3 oS", int'(oS), 8192);
      if (k == 3) chk("T4 B3 sS", int'(sS), 0);
      if (k >= 4) chk("T4 max oS", int'(oS), 32767);
      if (k >= 4) chk("T4 max sS", int'(sS), 1);
    end
    clr();
    for (int k = 1; k <= 6; k++) period(16'h8000, 4);
    chk("T4 min oS", int'(oS), -32768);
    chk("T4 min sS", int'(sS), 1);
    for (int k = 1; k <= 10; k++) period(16'd0, 4);
    chk("T4 drain oS", int'(oS), 0);
    chk("T4 drain sS", int'(sS), 0);

    // integrator wrap with a narrow accumulator
    clr();
    for (int k = 1; k <= 300; k++) begin
      period(16'd32767, 4);
      if (k >= 5) chk("T5 oW", int'(oW), 32767);
      if (k >= 5) chk("T5 sW", int'(sW), 0);
    end

    // simultaneous strobes: comb sees the integrator from before the edge
    clr();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); clkEnA = 1'b1; iIn = 16'd8;
    end
    @(negedge clk); clkEnA = 1'b1; clkEnB = 1'b1;
    @(negedge clk); clkEnA = 1'b0; clkEnB = 1'b0;
    @(posedge clk); #1;
    chk("T6 simul v1", int'(v1), 1);
    chk("T6 simul o1", int'(o1), 3);
    period(16'd8, 4);
    chk("T6 next o1", int'(o1), 5);
    period(16'd8, 0);
    chk("T6 stale v1", int'(v1), 1);
    chk("T6 stale o1", int'(o1), 0);

    // iClr together with clkEnB
    period(16'd8, 4);
    chk("T6 pre o1", int'(o1), 4);
    @(negedge clk); iClr = 1'b1; clkEnA = 1'b1; clkEnB = 1'b1;
    @(negedge clk); iClr = 1'b0; clkEnA = 1'b0; clkEnB = 1'b0;
    @(posedge clk); #1;
    chk("T6 clr v1", int'(v1), 0);
    chk("T6 clr v3", int'(v3), 0);
    chk("T6 clr o1", int'(o1), 0);
    chk("T6 clr s1", int'(s1), 0);
    period(16'd8, 4);
    chk("T6 after clr o1", int'(o1), 4);
    chk("T6 after clr v1", int'(v1), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
